// File: rtl/multicycle_alu.sv
// Registered EX-stage ALU with an iterative one-bit-per-cycle multiply/divide unit.
// Single-cycle ops finish at the start edge; MUL/DIV take WIDTH edges, then pulse done.
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUConf,
  input  logic             Sign,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_NOR = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_SRL = 5'b10000;
  localparam logic [4:0] OP_SRA = 5'b11000;
  localparam logic [4:0] OP_SLL = 5'b11001;
  localparam logic [4:0] OP_MUL = 5'b11010;
  localparam logic [4:0] OP_DIV = 5'b11011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [SHAMT_W-1:0] shamt;
  logic               slt;
  logic [WIDTH-1:0]   alu_res;

  assign shamt = In1[SHAMT_W-1:0];
  assign slt   = Sign ? ($signed(In1) < $signed(In2))
                      : (In1 < In2);

  always_comb begin
    alu_res = '0;
    unique case (ALUConf)
      OP_ADD:  alu_res = In1 + In2;
      OP_OR:   alu_res = In1 | In2;
      OP_AND:  alu_res = In1 & In2;
      OP_SUB:  alu_res = In1 - In2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR:  alu_res = ~(In1 | In2);
      OP_XOR:  alu_res = In1 ^ In2;
      OP_SRL:  alu_res = In2 >> shamt;
      OP_SRA:  alu_res = $signed(In2) >>> shamt;
      OP_SLL:  alu_res = In2 << shamt;
      default: alu_res = '0;
    endcase
  end

  // Iteration runs on magnitudes; signs are reapplied on the last step.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign a_neg = Sign & In1[WIDTH-1];
  assign b_neg = Sign & In2[WIDTH-1];
  assign a_abs = a_neg ? -In1 : In1;
  assign b_abs = b_neg ? -In2 : In2;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   rem_nxt;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] fin;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

  // acc_q holds {remainder, dividend-shifting-into-quotient}.
  assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opd_q};
  assign div_sub = div_sh[WIDTH-1:0] - opd_q;
  assign rem_nxt = div_ge ? div_sub : div_sh[WIDTH-1:0];
  assign div_nxt = {rem_nxt, acc_q[WIDTH-2:0], div_ge};

  assign fin = (state_q == S_MUL) ? mul_nxt : div_nxt;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_lo_q ? -fin : fin;
  assign quo_fix  = dz_q     ? '1
                  : neg_lo_q ? -fin[WIDTH-1:0]
                  : fin[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -fin[2*WIDTH-1:WIDTH]
                             : fin[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    res_d    = res_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ALUConf == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = CNT_W'(WIDTH);
            acc_d    = {{WIDTH{1'b0}}, b_abs};
            opd_d    = a_abs;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = 1'b0;
            dz_d     = 1'b0;
            busy_d   = 1'b1;
          end else if (ALUConf == OP_DIV) begin
            state_d  = S_DIV;
            cnt_d    = CNT_W'(WIDTH);
            acc_d    = {{WIDTH{1'b0}}, a_abs};
            opd_d    = b_abs;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            dz_d     = (In2 == '0);
            busy_d   = 1'b1;
          end else begin
            state_d = S_DONE;
            res_d   = alu_res;
            hi_d    = '0;
            zero_d  = (alu_res == '0);
            dbz_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        acc_d = fin;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (state_q == S_MUL) begin
            res_d  = prod_fix[WIDTH-1:0];
            hi_d   = prod_fix[2*WIDTH-1:WIDTH];
            zero_d = (prod_fix[WIDTH-1:0] == '0);
            dbz_d  = 1'b0;
          end else begin
            res_d  = quo_fix;
            hi_d   = rem_fix;
            zero_d = (quo_fix == '0);
            dbz_d  = dz_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Result      = res_q;
  assign Hi          = hi_q;
  assign Zero        = zero_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: stimulus pushes expected results,
// monitors pop and compare on every done pulse (32- and 8-bit instances).
module tb_multicycle_alu;

  localparam logic [4:0] ADD = 5'b00000;
  localparam logic [4:0] OR_ = 5'b00001;
  localparam logic [4:0] AND_ = 5'b00010;
  localparam logic [4:0] SUB = 5'b00110;
  localparam logic [4:0] SLT = 5'b00111;
  localparam logic [4:0] NOR_ = 5'b01100;
  localparam logic [4:0] XOR_ = 5'b01101;
  localparam logic [4:0] SRL = 5'b10000;
  localparam logic [4:0] SRA = 5'b11000;
  localparam logic [4:0] SLL = 5'b11001;
  localparam logic [4:0] MUL = 5'b11010;
  localparam logic [4:0] DIV = 5'b11011;
  localparam logic [4:0] BAD = 5'b00011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [4:0]  conf;
  logic        sign;
  logic [31:0] in1, in2, res, hi;
  logic        zero, busy, done, dbz;

  logic        start8;
  logic [4:0]  conf8;
  logic        sign8;
  logic [7:0]  in1_8, in2_8, res8, hi8;
  logic        zero8, busy8, done8, dbz8;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ALUConf(conf), .Sign(sign), .In1(in1), .In2(in2),
    .Result(res), .Hi(hi), .Zero(zero), .busy(busy),
    .done(done), .div_by_zero(dbz)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .ALUConf(conf8), .Sign(sign8), .In1(in1_8), .In2(in2_8),
    .Result(res8), .Hi(hi8), .Zero(zero8), .busy(busy8),
    .done(done8), .div_by_zero(dbz8)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run32 = 0;
  int run8 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", 32'(done), 32'd0);
      end else begin
        e32 = q32.pop_front();
        chk("result32", res, e32.res);
        chk("hi32", hi, e32.hi);
        chk("zero32", 32'(zero), 32'(e32.res == 0));
        chk("dbz32", 32'(dbz), 32'(e32.dbz));
        chk("latency32", 32'(cyc), 32'(e32.cyc));
      end
    end
    if (busy) run32++;
    else begin
      if (run32 != 0 && done) chk("busy_cycles32", 32'(run32), 32'd32);
      run32 = 0;
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'(done8), 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("result8", 32'(res8), e8.res);
        chk("hi8", 32'(hi8), e8.hi);
        chk("zero8", 32'(zero8), 32'(e8.res == 0));
        chk("dbz8", 32'(dbz8), 32'(e8.dbz));
        chk("latency8", 32'(cyc), 32'(e8.cyc));
      end
    end
    if (busy8) run8++;
    else begin
      if (run8 != 0 && done8) chk("busy_cycles8", 32'(run8), 32'd8);
      run8 = 0;
    end
  end

  // Called at a negedge; start is sampled at the next posedge.
  task automatic issue32(input logic [4:0] op, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [31:0] eh,
                         input logic ed, output int acc);
    exp_t e;
    conf  = op;
    sign  = sg;
    in1   = a;
    in2   = b;
    start = 1'b1;
    acc   = cyc + 1;
    e.res = er;
    e.hi  = eh;
    e.dbz = ed;
    e.cyc = acc + ((op == MUL || op == DIV) ? 32 : 0);
    q32.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue8(input logic [4:0] op, input logic sg,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [7:0] eh,
                        input logic ed);
    exp_t e;
    conf8  = op;
    sign8  = sg;
    in1_8  = a;
    in2_8  = b;
    start8 = 1'b1;
    e.res  = 32'(er);
    e.hi   = 32'(eh);
    e.dbz  = ed;
    e.cyc  = cyc + 1 + ((op == MUL || op == DIV) ? 8 : 0);
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    #1;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("timeout_pending", 32'(q32.size() + q8.size()), 32'd0);
      q32.delete();
      q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic op32(input logic [4:0] op, input logic sg,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [31:0] eh,
                      input logic ed);
    int acc;
    issue32(op, sg, a, b, er, eh, ed, acc);
    wait_idle();
  endtask

  initial begin
    int acc;
    reset  = 1'b1;
    start  = 1'b0;
    conf   = '0;
    sign   = 1'b0;
    in1    = '0;
    in2    = '0;
    start8 = 1'b0;
    conf8  = '0;
    sign8  = 1'b0;
    in1_8  = '0;
    in2_8  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_result", res, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    chk("rst_result8", 32'(res8), 32'd0);

    op32(ADD, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0);
    op32(SLT, 1, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 0);
    op32(SLT, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0);
    op32(SRA, 0, 32'd4, 32'h8000_0000, 32'hF800_0000, 32'd0, 0);
    op32(SRL, 0, 32'd4, 32'h8000_0000, 32'h0800_0000, 32'd0, 0);
    op32(SLL, 0, 32'd31, 32'd1, 32'h8000_0000, 32'd0, 0);
    op32(OR_, 0, 32'h0F0F_0000, 32'h00F0_F0F0, 32'h0FFF_F0F0, 32'd0, 0);
    op32(AND_, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 32'd0, 0);
    op32(SUB, 0, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd0, 0);
    op32(NOR_, 0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 32'd0, 0);
    op32(XOR_, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 32'd0, 0);
    op32(BAD, 0, 32'h1234_5678, 32'h1111_1111, 32'd0, 32'd0, 0);

    op32(MUL, 1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 0);
    op32(MUL, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    op32(DIV, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    op32(DIV, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
    op32(DIV, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    op32(DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);

    // Re-issue while busy and while done is showing; both must be dropped.
    issue32(MUL, 0, 32'd6, 32'd7, 32'd42, 32'd0, 0, acc);
    repeat (3) @(negedge clk);
    conf  = ADD;
    in1   = 32'd100;
    in2   = 32'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 32) @(negedge clk);
    conf  = SUB;
    in1   = 32'd9;
    in2   = 32'd1;
    start = 1'b1;
    @(negedge clk);
    chk("held_result", res, 32'd42);
    issue32(ADD, 0, 32'd2, 32'd3, 32'd5, 32'd0, 0, acc);
    wait_idle();

    op32(DIV, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);

    // Abort a divide partway through with reset.
    conf  = DIV;
    sign  = 1'b0;
    in1   = 32'd100;
    in2   = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_mid_div", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_result", res, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (40) @(negedge clk);

    issue8(MUL, 0, 8'h0F, 8'h11, 8'hFF, 8'h00, 0);
    wait_idle();
    issue8(MUL, 1, 8'hFE, 8'h03, 8'hFA, 8'hFF, 0);
    wait_idle();
    issue8(DIV, 1, 8'h80, 8'hFF, 8'h80, 8'h00, 0);
    wait_idle();
    issue8(ADD, 0, 8'hFF, 8'h01, 8'h00, 8'h00, 0);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("pending_at_end", 32'(q32.size() + q8.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered ALU with an iterative multiply/divide unit.
- Sits in the EX stage of the multi-cycle CPU and replaces the purely combinational ALU.
- Keeps the existing ALUConf encodings for logic, arithmetic, compare and shift operations, and adds signed/unsigned MUL and DIV/REM producing Hi/Lo.
- The controller drives a start/busy/done handshake so the FSM can stall on long operations.

Parameters:
WIDTH, 32, datapath width in bits (>= 8, power of two)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from In1[SHAMT_W-1:0]

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state and outputs
start  input  1  request: operands and ALUConf/Sign sampled when start=1 in IDLE
ALUConf  input  5  operation select (encodings below)
Sign  input  1  1 = signed compare/MUL/DIV, 0 = unsigned
In1  input  WIDTH  operand A (shift amount for shifts)
In2  input  WIDTH  operand B (shifted value for shifts)
Result  output  WIDTH  registered result; product low half / quotient for MUL/DIV
Hi  output  WIDTH  registered product high half / remainder; 0 for non-MUL/DIV ops
Zero  output  1  registered, equals (Result == 0), updated together with Result
busy  output  1  high while MUL/DIV iterates
done  output  1  one-cycle pulse when Result/Hi are valid and newly written
div_by_zero  output  1  registered flag, set with done on DIV with divisor 0, else 0

Behaviour:
- Op encodings:
  - 00000 ADD; 00001 OR; 00010 AND; 00110 SUB; 00111 SLT (signed per Sign, result 0/1 zero-extended).
  - 01100 NOR; 01101 XOR.
  - 10000 SRL; 11000 SRA; 11001 SLL.
  - 11010 MUL; 11011 DIV.
  - Any other code: Result=0, Hi=0, single-cycle.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SRA replicates In2[WIDTH-1].
- States: IDLE, MUL, DIV, DONE.
  - IDLE: start=1 with a single-cycle op → Result/Hi/Zero written at that edge, go to DONE.
  - IDLE: start=1 with MUL/DIV → latch operands (absolute values when Sign=1, with result-sign bits), counter=WIDTH, go to MUL/DIV.
  - MUL: shift-add, one bit per cycle. DIV: restoring shift-subtract, one bit per cycle. Counter decrements each edge; at counter==1 the final bit is processed, sign correction is applied, outputs are written, and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally; start is ignored in DONE.
- Latency (start sampled at edge N):
  - Single-cycle op: done high during cycle N..N+1.
  - MUL/DIV: done high during cycle after edge N+WIDTH, i.e. start→done = WIDTH+1 edges.
- busy=1 exactly in MUL/DIV states. start while busy or in DONE is ignored; operands are not re-sampled.
- Result/Hi/Zero/div_by_zero hold their last written value until the next completed op.
- MUL result: {Hi,Result} = full 2*WIDTH-bit product; signed when Sign=1.
- DIV result: Result=quotient truncated toward zero; Hi=remainder with the dividend's sign.
- DIV boundaries:
  - Divisor 0: Result=all ones, Hi=dividend (In1), div_by_zero=1. The full WIDTH-cycle latency still applies.
  - Signed MIN/-1: Result=MIN, Hi=0, div_by_zero=0.
- Reset:
  - All outputs 0, state IDLE, counter 0.
  - Reset asserted mid-MUL/DIV aborts the operation; no done pulse follows.
  - Reset has priority over start on the same edge.

Test Plan:
- Single-cycle ops: WIDTH=32, ADD 0xFFFFFFFF+1 → Result=0, Zero=1, done one cycle after start. SLT Sign=1, In1=-1, In2=1 → Result=1. Sign=0 same operands → Result=0.
- Shifts: SRA In1=4, In2=0x80000000 → 0xF8000000. SRL same operands → 0x08000000. SLL In1=31, In2=1 → 0x80000000.
- MUL: Sign=1, -3 × 7 → {Hi,Result}=0xFFFFFFFF_FFFFFFEB. Sign=0, 0xFFFFFFFF² → Hi=0xFFFFFFFE, Result=0x00000001. In both, busy high for 32 cycles and done at edge N+33.
- DIV: Sign=1, -7/2 → Result=-3, Hi=-1. 0x80000000/-1 → Result=0x80000000, Hi=0. Divisor 0 with In1=5 → Result=0xFFFFFFFF, Hi=5, div_by_zero=1.
- Handshake: start re-asserted with new operands during busy and during DONE → ignored, first op's result unchanged. start in the cycle after done → accepted.
- Reset mid-DIV at cycle 10 → outputs 0, busy=0, no done. WIDTH=8 instance: MUL 0x0F×0x11 → Hi=0x00, Result=0xFF, latency 9 edges.
